// File: rtl/dtree_seq_walker.sv
// dtree_seq_walker: programmable decision-tree classifier that walks one node per clock.
// Optional depth guard is built when DTREE_DEPTH_GUARD_EN is defined.
module dtree_seq_walker #(
  parameter int N_FEAT    = 64,
  parameter int FEAT_W    = 8,
  parameter int N_NODES   = 64,
  parameter int CLASS_W   = 5,
  parameter int MAX_STEPS = 16,
  localparam int FI_W     = $clog2(N_FEAT),
  localparam int NI_W     = $clog2(N_NODES),
  localparam int PW       = $clog2(FEAT_W + 1),
  localparam int NODE_W   = 1 + FI_W + PW + FEAT_W + 2 * NI_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_features,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  input  logic                     cfg_we,
  input  logic [NI_W-1:0]          cfg_addr,
  input  logic [NODE_W-1:0]        cfg_wdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WALK = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [NODE_W-1:0]  tbl [N_NODES];
  logic [FEAT_W-1:0]  feat_p0 [N_FEAT];
  logic [NI_W-1:0]    node_p0;
  logic [CLASS_W-1:0] cls_p1;

  logic               nd_leaf;
  logic [FI_W-1:0]    nd_fidx;
  logic [PW-1:0]      nd_prec;
  logic [FEAT_W-1:0]  nd_thr;
  logic [NI_W-1:0]    nd_left;
  logic [NI_W-1:0]    nd_right;
  logic [FEAT_W-1:0]  fsel;
  logic               go_left;
  logic [NI_W-1:0]    nxt_node;
  logic               accept;

  // Precision values beyond the feature width saturate to the full width.
  function automatic logic [PW-1:0] sat_prec(input logic [PW-1:0] p);
    return (p > PW'(FEAT_W)) ? PW'(FEAT_W) : p;
  endfunction

  // Keep the top prec MSBs; a shift of FEAT_W (prec=0) yields zero.
  function automatic logic [FEAT_W-1:0] trunc_feat(input logic [FEAT_W-1:0] f,
                                                   input logic [PW-1:0]     p);
    logic [PW-1:0] sh;
    sh = PW'(FEAT_W) - sat_prec(p);
    return f >> sh;
  endfunction

  assign {nd_leaf, nd_fidx, nd_prec, nd_thr, nd_left, nd_right} = tbl[node_p0];

  // Indices with no matching feature read as zero.
  always_comb begin
    fsel = '0;
    for (int i = 0; i < N_FEAT; i++)
      if (nd_fidx == FI_W'(i)) fsel = feat_p0[i];
  end

  assign go_left  = (trunc_feat(fsel, nd_prec) <= nd_thr);
  assign nxt_node = go_left ? nd_left : nd_right;

  assign in_ready  = (state == S_IDLE) && !cfg_we;
  assign accept    = in_ready && in_valid;
  assign out_valid = (state == S_DONE);
  assign out_class = cls_p1;

`ifdef DTREE_DEPTH_GUARD_EN
  localparam int SW = $clog2(MAX_STEPS + 1);
  logic [SW-1:0] steps_p0;
  logic          err_p1;
  assign out_err = err_p1;
`else
  assign out_err = 1'b0;
`endif

  // stage p0: feature capture (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept)
      for (int i = 0; i < N_FEAT; i++)
        feat_p0[i] <= in_features[i*FEAT_W +: FEAT_W];
  end

  // stage p1: walk control, node table and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      node_p0 <= '0;
      cls_p1  <= '0;
      for (int i = 0; i < N_NODES; i++)
        tbl[i] <= {1'b1, {(NODE_W-1){1'b0}}};
`ifdef DTREE_DEPTH_GUARD_EN
      steps_p0 <= '0;
      err_p1   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_we) begin
            tbl[cfg_addr] <= cfg_wdata;
          end else if (in_valid) begin
            state   <= S_WALK;
            node_p0 <= '0;
`ifdef DTREE_DEPTH_GUARD_EN
            steps_p0 <= '0;
`endif
          end
        end
        S_WALK: begin
          if (nd_leaf) begin
            cls_p1 <= nd_thr[CLASS_W-1:0];
            state  <= S_DONE;
`ifdef DTREE_DEPTH_GUARD_EN
            err_p1 <= 1'b0;
          end else if (steps_p0 == SW'(MAX_STEPS - 1)) begin
            cls_p1 <= '1;
            err_p1 <= 1'b1;
            state  <= S_DONE;
`endif
          end else begin
            node_p0 <= nxt_node;
          end
`ifdef DTREE_DEPTH_GUARD_EN
          steps_p0 <= steps_p0 + SW'(1);
`endif
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_seq_walker.sv
// Self-checking bench for dtree_seq_walker: scoreboarded walks over programmed trees,
// stall, config priority, back-to-back throughput, mid-walk reset and the depth guard.
module tb_dtree_seq_walker;

  localparam int N_FEAT    = 64;
  localparam int FEAT_W    = 8;
  localparam int N_NODES   = 64;
  localparam int CLASS_W   = 5;
  localparam int MAX_STEPS = 16;
  localparam int FI_W      = $clog2(N_FEAT);
  localparam int NI_W      = $clog2(N_NODES);
  localparam int PW        = $clog2(FEAT_W + 1);
  localparam int NODE_W    = 1 + FI_W + PW + FEAT_W + 2 * NI_W;
  localparam int VW        = N_FEAT * FEAT_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [VW-1:0]      in_features = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [CLASS_W-1:0] out_class;
  logic               out_err;
  logic               cfg_we = 1'b0;
  logic [NI_W-1:0]    cfg_addr = '0;
  logic [NODE_W-1:0]  cfg_wdata = '0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [CLASS_W-1:0] cls;
    logic               err;
    int                 lat;
  } exp_t;

  exp_t sb[$];

  dtree_seq_walker #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .N_NODES(N_NODES),
    .CLASS_W(CLASS_W), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_features(in_features),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_err(out_err),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [NODE_W-1:0] mk_node(input int leaf, input int fidx, input int prec,
                                                input int thr, input int lft, input int rgt);
    return {leaf[0], fidx[FI_W-1:0], prec[PW-1:0], thr[FEAT_W-1:0], lft[NI_W-1:0], rgt[NI_W-1:0]};
  endfunction

  function automatic exp_t mk_exp(input int cls, input int err, input int lat);
    exp_t e;
    e.cls = cls[CLASS_W-1:0];
    e.err = err[0];
    e.lat = lat;
    return e;
  endfunction

  task automatic gen_vec(input int idx, input int val, output logic [VW-1:0] v);
    for (int i = 0; i < N_FEAT; i++) v[i*FEAT_W +: FEAT_W] = FEAT_W'($urandom);
    v[idx*FEAT_W +: FEAT_W] = FEAT_W'(val);
  endtask

  task automatic write_node(input int addr, input logic [NODE_W-1:0] w);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr[NI_W-1:0]; cfg_wdata = w;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_out(input int lim, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i <= lim; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input logic [VW-1:0] v, input int lim, output int lat, output bit ok);
    @(negedge clk);
    in_features = v;
    in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lim, lat, ok);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic program_tree();
    write_node(0, mk_node(0, 3, 3, 3, 1, 2));
    write_node(1, mk_node(1, 0, 0, 13, 0, 0));
    write_node(2, mk_node(1, 0, 0, 'hE2, 0, 0));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_class !== '0) begin bad++; $display("FAIL reset_out_class: got %0d want 0", out_class); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
  endtask

  task automatic test_default_walk();
    logic [VW-1:0] v;
    exp_t e;
    int lat;
    bit ok;
    out_ready = 1'b1;
    gen_vec(0, $urandom_range(0, 255), v);
    sb.push_back(mk_exp(0, 0, 1));
    run_vec(v, 50, lat, ok);
    e = sb.pop_front();
    total++;
    if (!ok) begin
      bad++; $display("FAIL default_walk timeout: got no out_valid want out_valid");
    end else begin
      if (out_class !== e.cls) begin bad++; $display("FAIL default_class: got %0d want %0d", out_class, e.cls); end
      total++; if (out_err !== e.err) begin bad++; $display("FAIL default_err: got %b want %b", out_err, e.err); end
      total++; if (lat != e.lat) begin bad++; $display("FAIL default_latency: got %0d want %0d", lat, e.lat); end
    end
  endtask

  typedef struct {
    int n0f; int n0p; int n0t; int fidx; int fval; int cls;
  } tcase_t;

  task automatic test_tree_walk();
    tcase_t tc [9];
    logic [VW-1:0] v;
    exp_t e;
    int lat;
    bit ok;
    tc = '{'{3, 3, 3, 3, 'h7F, 13}, '{3, 3, 3, 3, 'h80, 2}, '{3, 3, 3, 3, 'h60, 13},
           '{3, 3, 3, 3, 'hFF, 2},  '{3, 3, 3, 3, 'h00, 13}, '{5, 15, 'h40, 5, 'h40, 13},
           '{5, 15, 'h40, 5, 'h41, 2}, '{9, 0, 0, 9, 'hFF, 13}, '{7, 8, 'hFE, 7, 'hFF, 2}};
    out_ready = 1'b1;
    program_tree();
    foreach (tc[i]) begin
      write_node(0, mk_node(0, tc[i].n0f, tc[i].n0p, tc[i].n0t, 1, 2));
      gen_vec(tc[i].fidx, tc[i].fval, v);
      sb.push_back(mk_exp(tc[i].cls, 0, 2));
      run_vec(v, 50, lat, ok);
      e = sb.pop_front();
      total++;
      if (!ok) begin
        bad++; $display("FAIL tree_walk case %0d timeout: got no out_valid want out_valid", i);
      end else begin
        if (out_class !== e.cls) begin bad++; $display("FAIL tree_class case %0d: got %0d want %0d", i, out_class, e.cls); end
        total++; if (out_err !== e.err) begin bad++; $display("FAIL tree_err case %0d: got %b want %b", i, out_err, e.err); end
        total++; if (lat != e.lat) begin bad++; $display("FAIL tree_latency case %0d: got %0d want %0d", i, lat, e.lat); end
      end
    end
    write_node(0, mk_node(0, 3, 3, 3, 1, 2));
  endtask

  task automatic test_stall();
    logic [VW-1:0] v;
    exp_t e;
    int lat;
    bit ok;
    out_ready = 1'b0;
    gen_vec(3, 'h7F, v);
    sb.push_back(mk_exp(13, 0, 2));
    run_vec(v, 50, lat, ok);
    e = sb.pop_front();
    total++; if (!ok) begin bad++; $display("FAIL stall_walk timeout: got no out_valid want out_valid"); end
    for (int i = 0; i < 5; i++) begin
      cfg_we = 1'b1; cfg_addr = NI_W'(1); cfg_wdata = mk_node(1, 0, 0, 7, 0, 0);
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid cyc %0d: got %b want 1", i, out_valid); end
      total++; if (out_class !== e.cls) begin bad++; $display("FAIL stall_class cyc %0d: got %0d want %0d", i, out_class, e.cls); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc %0d: got %b want 0", i, in_ready); end
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release: got out_valid=%b want 0", out_valid); end
    sb.push_back(mk_exp(13, 0, 2));
    run_vec(v, 50, lat, ok);
    e = sb.pop_front();
    total++;
    if (!ok) begin bad++; $display("FAIL stall_cfg_ignored timeout: got no out_valid want out_valid"); end
    else if (out_class !== e.cls) begin bad++; $display("FAIL stall_cfg_ignored: got class %0d want %0d", out_class, e.cls); end
  endtask

  task automatic test_cfg_priority();
    logic [VW-1:0] v;
    exp_t e;
    int lat;
    bit ok;
    out_ready = 1'b1;
    gen_vec(3, 'h7F, v);
    sb.push_back(mk_exp(9, 0, 2));
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = NI_W'(1); cfg_wdata = mk_node(1, 0, 0, 9, 0, 0);
    in_features = v; in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL prio_in_ready_cfg: got %b want 0", in_ready); end
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL prio_in_ready_next: got %b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    gen_vec(3, 'h80, v);
    in_features = v;
    wait_out(50, lat, ok);
    e = sb.pop_front();
    total++;
    if (!ok) begin
      bad++; $display("FAIL prio_walk timeout: got no out_valid want out_valid");
    end else begin
      if (out_class !== e.cls) begin bad++; $display("FAIL prio_class: got %0d want %0d", out_class, e.cls); end
      total++; if (lat != e.lat) begin bad++; $display("FAIL prio_latency: got %0d want %0d", lat, e.lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] v;
    exp_t e;
    int hs = 0;
    int outs = 0;
    int last = -1;
    bit stop = 1'b0;
    out_ready = 1'b1;
    gen_vec(3, 'h80, v);
    @(negedge clk);
    in_features = v;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (stop) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected_out: got class %0d want no output", out_class);
        end else begin
          e = sb.pop_front();
          if (out_class !== e.cls) begin bad++; $display("FAIL b2b_class: got %0d want %0d", out_class, e.cls); end
          total++; if (out_err !== e.err) begin bad++; $display("FAIL b2b_err: got %b want %b", out_err, e.err); end
        end
        outs++;
      end
      if (in_valid && in_ready === 1'b1) begin
        sb.push_back(mk_exp(2, 0, 2));
        if (last >= 0) begin
          total++; if (cyc - last != 4) begin bad++; $display("FAIL b2b_period: got %0d want 4", cyc - last); end
        end
        last = cyc;
        hs++;
        if (hs == 3) stop = 1'b1;
      end
      if (outs == 3) break;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (outs != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", outs); end
    sb.delete();
  endtask

  task automatic test_reset_mid_walk();
    logic [VW-1:0] v;
    out_ready = 1'b1;
    gen_vec(3, 'h80, v);
    @(negedge clk);
    in_features = v; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    total++; if (out_class !== '0) begin bad++; $display("FAIL midrst_class: got %0d want 0", out_class); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_hold cyc %0d: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_depth_guard();
    logic [VW-1:0] v;
    exp_t e;
    int lat;
    bit ok;
    out_ready = 1'b1;
    write_node(0, mk_node(0, 0, 0, 0, 0, 0));
    gen_vec(0, 'hFF, v);
`ifdef DTREE_DEPTH_GUARD_EN
    sb.push_back(mk_exp('h1F, 1, MAX_STEPS));
    run_vec(v, 100, lat, ok);
    e = sb.pop_front();
    total++;
    if (!ok) begin
      bad++; $display("FAIL guard timeout: got no out_valid want out_valid");
    end else begin
      if (out_class !== e.cls) begin bad++; $display("FAIL guard_class: got %0d want %0d", out_class, e.cls); end
      total++; if (out_err !== e.err) begin bad++; $display("FAIL guard_err: got %b want %b", out_err, e.err); end
      total++; if (lat != e.lat) begin bad++; $display("FAIL guard_latency: got %0d want %0d", lat, e.lat); end
    end
`else
    run_vec(v, 40, lat, ok);
    total++; if (ok) begin bad++; $display("FAIL noguard_hang: got out_valid after %0d want none", lat); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL noguard_in_ready: got %b want 0", in_ready); end
`endif
    pulse_reset();
    sb.push_back(mk_exp(0, 0, 1));
    run_vec(v, 50, lat, ok);
    e = sb.pop_front();
    total++;
    if (!ok) begin
      bad++; $display("FAIL guard_recover timeout: got no out_valid want out_valid");
    end else begin
      if (out_class !== e.cls) begin bad++; $display("FAIL guard_recover_class: got %0d want %0d", out_class, e.cls); end
      total++; if (out_err !== e.err) begin bad++; $display("FAIL guard_recover_err: got %b want %b", out_err, e.err); end
    end
  endtask

  initial begin
    test_reset();
    test_default_walk();
    test_tree_walk();
    test_stall();
    test_cfg_priority();
    test_back_to_back();
    test_reset_mid_walk();
    program_tree();
    test_depth_guard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running want finished");
    $fatal(1, "timeout");
  end

endmodule
